// File: rtl/contrast_row_scheduler_if.sv
// Control bundle between the contrast row scheduler, the row-buffer bank,
// the filter accelerator handshake and the filter buffer write port.
interface contrast_row_scheduler_if;
  logic        filter_begin;
  logic        row_valid;
  logic        filbuf_wready;
  logic        rowbuf_rden;
  logic [7:0]  rowbuf_rdaddr;
  logic        tap_load;
  logic        rowbuf_wren;
  logic [7:0]  rowbuf_wraddr;
  logic [4:0]  ring_head;
  logic        filter_ap_start;
  logic        filter_ap_ready;
  logic        filter_ap_done;
  logic        filbuf_wren;
  logic [13:0] filbuf_wraddr;
  logic        busy;
  logic        done;

  modport master (
    input  filter_begin, row_valid, filbuf_wready, filter_ap_ready, filter_ap_done,
    output rowbuf_rden, rowbuf_rdaddr, tap_load, rowbuf_wren, rowbuf_wraddr,
           ring_head, filter_ap_start, filbuf_wren, filbuf_wraddr, busy, done
  );

  modport slave (
    output filter_begin, row_valid, filbuf_wready, filter_ap_ready, filter_ap_done,
    input  rowbuf_rden, rowbuf_rdaddr, tap_load, rowbuf_wren, rowbuf_wraddr,
           ring_head, filter_ap_start, filbuf_wren, filbuf_wraddr, busy, done
  );
endinterface

// File: rtl/contrast_row_scheduler.sv
// Frame sequencer for the contrast filter: walks rows/columns, rotates the
// KERNEL-row ring, launches the accelerator per output pixel and writes results.
module contrast_row_scheduler #(
  parameter int ROW_LEN  = 128,
  parameter int NUM_ROWS = 128,
  parameter int KERNEL   = 17
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  contrast_row_scheduler_if.master  bus
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WAIT_ROW  = 4'd1;
  localparam logic [3:0] S_READ      = 4'd2;
  localparam logic [3:0] S_CAPTURE   = 4'd3;
  localparam logic [3:0] S_STORE     = 4'd4;
  localparam logic [3:0] S_LAUNCH    = 4'd5;
  localparam logic [3:0] S_WAIT_DONE = 4'd6;
  localparam logic [3:0] S_WRITE     = 4'd7;
  localparam logic [3:0] S_ADVANCE   = 4'd8;
  localparam logic [3:0] S_FINISH    = 4'd9;

  localparam logic [7:0]  COL_LAST   = 8'(ROW_LEN - 1);
  localparam logic [15:0] ROW_LAST   = 16'(NUM_ROWS - 1);
  localparam logic [15:0] FIRST_OUT  = 16'(KERNEL - 1);
  localparam logic [4:0]  HEAD_LAST  = 5'(KERNEL - 1);

  logic [3:0]  state_q, state_d;
  logic [7:0]  col_q, col_d;
  logic [15:0] row_q, row_d;
  logic [4:0]  head_q, head_d;
  logic [13:0] faddr_q, faddr_d;

  // NOTE: every next-state value gets its default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    head_d  = head_q;
    faddr_d = faddr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.filter_begin) begin
          col_d   = '0;
          row_d   = '0;
          head_d  = '0;
          faddr_d = '0;
          state_d = S_WAIT_ROW;
        end
      end
      S_WAIT_ROW:  if (bus.row_valid) state_d = S_READ;
      S_READ:      state_d = S_CAPTURE;
      S_CAPTURE:   state_d = S_STORE;
      // Rows before the ring is full only prime it; no output pixel yet.
      S_STORE:     state_d = (row_q >= FIRST_OUT) ? S_LAUNCH : S_ADVANCE;
      S_LAUNCH: begin
        if (bus.filter_ap_ready)
          state_d = bus.filter_ap_done ? S_WRITE : S_WAIT_DONE;
      end
      S_WAIT_DONE: if (bus.filter_ap_done) state_d = S_WRITE;
      S_WRITE: begin
        if (bus.filbuf_wready) begin
          faddr_d = faddr_q + 14'd1;
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (col_q < COL_LAST) begin
          col_d   = col_q + 8'd1;
          state_d = S_READ;
        end else begin
          col_d   = '0;
          head_d  = (head_q == HEAD_LAST) ? 5'd0 : head_q + 5'd1;
          row_d   = row_q + 16'd1;
          state_d = (row_q == ROW_LAST) ? S_FINISH : S_WAIT_ROW;
        end
      end
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      head_q  <= '0;
      faddr_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      head_q  <= head_d;
      faddr_q <= faddr_d;
    end
  end

  // Strobes decode straight from the state register, so reset clears them at once.
  assign bus.rowbuf_rden     = (state_q == S_READ);
  assign bus.rowbuf_rdaddr   = col_q;
  assign bus.tap_load        = (state_q == S_CAPTURE);
  assign bus.rowbuf_wren     = (state_q == S_STORE);
  assign bus.rowbuf_wraddr   = col_q;
  assign bus.ring_head       = head_q;
  assign bus.filter_ap_start = (state_q == S_LAUNCH);
  assign bus.filbuf_wren     = (state_q == S_WRITE) && bus.filbuf_wready;
  assign bus.filbuf_wraddr   = faddr_q;
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.done            = (state_q == S_FINISH);

endmodule

// File: tb/tb_contrast_row_scheduler.sv
// Directed bench for contrast_row_scheduler with a small accelerator model:
// ROW_LEN=4, NUM_ROWS=18, KERNEL=17 gives 8 output pixels per frame.
module tb_contrast_row_scheduler;

  localparam int ROW_LEN  = 4;
  localparam int NUM_ROWS = 18;
  localparam int KERNEL   = 17;
  localparam int BUDGET   = 4000;

  logic clk;
  logic rst_n;
  contrast_row_scheduler_if bus();

  contrast_row_scheduler #(
    .ROW_LEN (ROW_LEN),
    .NUM_ROWS(NUM_ROWS),
    .KERNEL  (KERNEL)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Accelerator model: mode 0 = ready at once, done 3 cycles later;
  // mode 1 = ready and done in the same cycle.
  int accel_mode = 0;
  initial begin
    int done_cnt;
    done_cnt = 0;
    bus.filter_ap_ready = 1'b0;
    bus.filter_ap_done  = 1'b0;
    forever begin
      @(negedge clk);
      bus.filter_ap_ready = 1'b0;
      bus.filter_ap_done  = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) bus.filter_ap_done = 1'b1;
      end
      if (bus.filter_ap_start) begin
        bus.filter_ap_ready = 1'b1;
        if (accel_mode == 1) bus.filter_ap_done = 1'b1;
        else done_cnt = 3;
      end
    end
  end

  // Event monitor: logs filter-buffer writes and counts strobes.
  logic [13:0] wr_log[$];
  int n_rowwr = 0, n_done = 0, n_start = 0, start_run = 0, max_start_run = 0;
  always @(negedge clk) begin
    if (bus.filbuf_wren) wr_log.push_back(bus.filbuf_wraddr);
    if (bus.rowbuf_wren) n_rowwr++;
    if (bus.done) n_done++;
    if (bus.filter_ap_start) begin
      n_start++;
      start_run++;
      if (start_run > max_start_run) max_start_run = start_run;
    end else begin
      start_run = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic start_frame();
    @(negedge clk);
    bus.filter_begin = 1'b1;
    @(negedge clk);
    bus.filter_begin = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input int base);
    check({tag, "_nwrites"}, 32'(wr_log.size() - base), 32'd8);
    for (int i = 0; i < 8; i++)
      if (base + i < wr_log.size())
        check({tag, "_addr"}, 32'(wr_log[base + i]), 32'(i));
  endtask

  initial begin
    int base, rw0, d0, s0, cnt, k;
    bit seen;

    rst_n             = 1'b0;
    bus.filter_begin  = 1'b0;
    bus.row_valid     = 1'b1;
    bus.filbuf_wready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_busy",      32'(bus.busy),            32'd0);
    check("rst_done",      32'(bus.done),            32'd0);
    check("rst_ring_head", 32'(bus.ring_head),       32'd0);
    check("rst_fwaddr",    32'(bus.filbuf_wraddr),   32'd0);
    check("rst_ap_start",  32'(bus.filter_ap_start), 32'd0);
    check("rst_fwren",     32'(bus.filbuf_wren),     32'd0);

    // Nominal frame
    base = wr_log.size(); rw0 = n_rowwr; d0 = n_done; s0 = n_start;
    start_frame();
    check("t1_busy_after_begin", 32'(bus.busy), 32'd1);
    wait_done("t1");
    check_writes("t1", base);
    check("t1_rowbuf_wren", 32'(n_rowwr - rw0), 32'd72);
    check("t1_ring_head",   32'(bus.ring_head), 32'd1);
    check("t1_done_pulses", 32'(n_done - d0),   32'd1);
    check("t1_busy_after",  32'(bus.busy),      32'd0);
    check("t1_ap_starts",   32'(n_start - s0),  32'd8);

    // Backpressure at the third output
    base = wr_log.size();
    start_frame();
    seen = 1'b0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      if (bus.filbuf_wraddr == 14'd2) seen = 1'b1;
      else @(negedge clk);
    end
    check("t2_reach_out3", 32'(seen), 32'd1);
    bus.filbuf_wready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.filbuf_wren) cnt++;
    end
    check("t2_stall_wren",  32'(cnt),               32'd0);
    check("t2_stall_addr",  32'(bus.filbuf_wraddr), 32'd2);
    check("t2_stall_busy",  32'(bus.busy),          32'd1);
    bus.filbuf_wready = 1'b1;
    wait_done("t2");
    check_writes("t2", base);

    // Accelerator answers ready and done together
    accel_mode = 1;
    base = wr_log.size(); s0 = n_start;
    start_frame();
    wait_done("t3");
    check_writes("t3", base);
    check("t3_ap_starts",    32'(n_start - s0),  32'd8);
    check("t3_ap_start_run", 32'(max_start_run), 32'd1);
    accel_mode = 0;

    // row_valid gap before row 5
    base = wr_log.size();
    start_frame();
    k = 0;
    for (int i = 0; i < BUDGET && k < 17; i++) begin
      @(negedge clk);
      if (bus.rowbuf_wren) k++;
    end
    check("t4_row4_started", 32'(k), 32'd17);
    bus.row_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk);
      if (bus.ring_head == 5'd5) seen = 1'b1;
    end
    check("t4_ring_head5", 32'(seen), 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rowbuf_rden || bus.rowbuf_wren) cnt++;
    end
    check("t4_gap_strobes", 32'(cnt), 32'd0);
    bus.row_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.rowbuf_rden) seen = 1'b1;
    end
    check("t4_resume_rden",  32'(seen),              32'd1);
    check("t4_resume_col",   32'(bus.rowbuf_rdaddr), 32'd0);
    check("t4_resume_head",  32'(bus.ring_head),     32'd5);
    wait_done("t4");
    check_writes("t4", base);

    // Reset during WAIT_DONE of output 4
    start_frame();
    seen = 1'b0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk);
      if (bus.filbuf_wraddr == 14'd3 && bus.filter_ap_start) seen = 1'b1;
    end
    check("t5_reach_launch4", 32'(seen), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_busy",     32'(bus.busy),            32'd0);
    check("t5_async_fwaddr",   32'(bus.filbuf_wraddr),   32'd0);
    check("t5_async_head",     32'(bus.ring_head),       32'd0);
    check("t5_async_ap_start", 32'(bus.filter_ap_start), 32'd0);
    check("t5_async_fwren",    32'(bus.filbuf_wren),     32'd0);
    base = wr_log.size(); rw0 = n_rowwr;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_post_writes", 32'(wr_log.size() - base), 32'd0);
    check("t5_post_rowwr",  32'(n_rowwr - rw0),        32'd0);
    check("t5_post_busy",   32'(bus.busy),             32'd0);
    base = wr_log.size();
    start_frame();
    wait_done("t5");
    check_writes("t5", base);

    // filter_begin mid-frame and coincident with FINISH are ignored
    base = wr_log.size(); d0 = n_done;
    start_frame();
    seen = 1'b0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk);
      if (bus.ring_head == 5'd10) seen = 1'b1;
    end
    check("t6_reach_row10", 32'(seen), 32'd1);
    bus.filter_begin = 1'b1;
    @(negedge clk);
    bus.filter_begin = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("t6_done_seen", 32'(seen), 32'd1);
    bus.filter_begin = 1'b1;
    @(negedge clk);
    bus.filter_begin = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_busy_after",  32'(bus.busy),      32'd0);
    check("t6_done_pulses", 32'(n_done - d0),   32'd1);
    check("t6_ring_head",   32'(bus.ring_head), 32'd1);
    check_writes("t6", base);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
